// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared types and constants for the UART command sequencer.
package uart_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_CHECK,
        ST_REQ,
        ST_WAIT_SENS,
        ST_SEND0,
        ST_WAIT0,
        ST_SEND1,
        ST_WAIT1
    } state_e;

    localparam logic [7:0] ERR_CMD         = 8'hFF;
    localparam logic [7:0] ERR_ADDR        = 8'hFE;
    localparam logic [7:0] ERR_TIMEOUT     = 8'hFD;
    localparam logic [7:0] DEFAULT_MAX_CMD = 8'h06;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of receiver, sensor and transmitter signals around the command sequencer.
interface uart_cmd_ctrl_if;

    logic       rx_done;
    logic [7:0] rx_data;
    logic       sensor_req;
    logic [7:0] sensor_cmd;
    logic [4:0] sensor_addr;
    logic       sensor_ready;
    logic [7:0] sensor_status;
    logic [7:0] sensor_value;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       busy;

    // The sequencer is the master: it owns the sensor request bus and tx strobe.
    modport master (
        input  rx_done, rx_data, sensor_ready, sensor_status, sensor_value, tx_busy,
        output sensor_req, sensor_cmd, sensor_addr, tx_start, tx_data, busy
    );

    modport slave (
        output rx_done, rx_data, sensor_ready, sensor_status, sensor_value, tx_busy,
        input  sensor_req, sensor_cmd, sensor_addr, tx_start, tx_data, busy
    );

endinterface

// File: rtl/uart_cmd_ctrl_byte_event_det.sv
// Rising-edge detector on the receiver's byte-available level, with byte pass-through.
module byte_event_det (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_done_i,
    input  logic [7:0] rx_data_i,
    output logic       event_o,
    output logic [7:0] data_o
);

    logic rxDonePrev_q;

    // Resets high so a level already present at reset release is not an event.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rxDonePrev_q <= 1'b1;
        end else begin
            rxDonePrev_q <= rx_done_i;
        end
    end

    assign event_o = rx_done_i & ~rxDonePrev_q;
    assign data_o  = rx_data_i;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Collects {command, address} bytes, validates them, queries the sensor unit
// under a timeout and returns a two-byte response through the UART transmitter.
module uart_cmd_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int         NUM_SENSORS    = 32,
    parameter logic [7:0] MAX_CMD        = DEFAULT_MAX_CMD,
    parameter int         BYTE_TIMEOUT   = 5_208_000,
    parameter int         SENSOR_TIMEOUT = 50_000_000
) (
    input  logic            clk_i,
    input  logic            reset_i,
    uart_cmd_ctrl_if.master bus
);

    localparam int CNT_MAX = (BYTE_TIMEOUT > SENSOR_TIMEOUT) ? BYTE_TIMEOUT : SENSOR_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BYTE_LIMIT = CNT_W'(BYTE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SENS_LIMIT = CNT_W'(SENSOR_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [8:0]       ADDR_LIMIT = 9'(NUM_SENSORS);

    logic       byteEvent;
    logic [7:0] byteData;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmdByte_q, cmdByte_d;
    logic [7:0]       addrByte_q, addrByte_d;
    logic [7:0]       resp0_q, resp0_d;
    logic [7:0]       resp1_q, resp1_d;
    logic             seenBusy_q, seenBusy_d;
    logic             sensorReq;
    logic             txStart;
    logic             holdReq;

    byte_event_det u_byte_event_det (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .rx_done_i (bus.rx_done),
        .rx_data_i (bus.rx_data),
        .event_o   (byteEvent),
        .data_o    (byteData)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cmdByte_q  <= '0;
            addrByte_q <= '0;
            resp0_q    <= '0;
            resp1_q    <= '0;
            seenBusy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmdByte_q  <= cmdByte_d;
            addrByte_q <= addrByte_d;
            resp0_q    <= resp0_d;
            resp1_q    <= resp1_d;
            seenBusy_q <= seenBusy_d;
        end
    end

    // One counter serves both the inter-byte and the sensor timeout; it saturates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
        cmdByte_d  = cmdByte_q;
        addrByte_d = addrByte_q;
        resp0_d    = resp0_q;
        resp1_d    = resp1_q;
        seenBusy_d = seenBusy_q;
        sensorReq  = 1'b0;
        txStart    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (byteEvent) begin
                    cmdByte_d = byteData;
                    cnt_d     = '0;
                    state_d   = ST_GET_ADDR;
                end
            end
            ST_GET_ADDR: begin
                if (byteEvent) begin
                    addrByte_d = byteData;
                    state_d    = ST_CHECK;
                end else if (cnt_q == BYTE_LIMIT) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (cmdByte_q > MAX_CMD) begin
                    resp0_d = ERR_CMD;
                    resp1_d = 8'h00;
                    state_d = ST_SEND0;
                end else if ({1'b0, addrByte_q} >= ADDR_LIMIT) begin
                    resp0_d = ERR_ADDR;
                    resp1_d = 8'h00;
                    state_d = ST_SEND0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                sensorReq = 1'b1;
                cnt_d     = '0;
                state_d   = ST_WAIT_SENS;
            end
            ST_WAIT_SENS: begin
                if (bus.sensor_ready) begin
                    resp0_d = bus.sensor_status;
                    resp1_d = bus.sensor_value;
                    state_d = ST_SEND0;
                end else if (cnt_q == SENS_LIMIT) begin
                    resp0_d = ERR_TIMEOUT;
                    resp1_d = 8'h00;
                    state_d = ST_SEND0;
                end
            end
            ST_SEND0: begin
                if (!bus.tx_busy) begin
                    txStart    = 1'b1;
                    seenBusy_d = 1'b0;
                    state_d    = ST_WAIT0;
                end
            end
            ST_WAIT0: begin
                if (bus.tx_busy) begin
                    seenBusy_d = 1'b1;
                end else if (seenBusy_q) begin
                    state_d = ST_SEND1;
                end
            end
            ST_SEND1: begin
                if (!bus.tx_busy) begin
                    txStart    = 1'b1;
                    seenBusy_d = 1'b0;
                    state_d    = ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                if (bus.tx_busy) begin
                    seenBusy_d = 1'b1;
                end else if (seenBusy_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Held outputs read zero outside a transaction so reset clears them at once.
    assign holdReq = (state_q == ST_REQ)   || (state_q == ST_WAIT_SENS) ||
                     (state_q == ST_SEND0) || (state_q == ST_WAIT0) ||
                     (state_q == ST_SEND1) || (state_q == ST_WAIT1);

    assign bus.sensor_req  = sensorReq;
    assign bus.tx_start    = txStart;
    assign bus.sensor_cmd  = holdReq ? cmdByte_q : 8'h00;
    assign bus.sensor_addr = holdReq ? addrByte_q[4:0] : 5'd0;
    assign bus.tx_data     = ((state_q == ST_SEND0) || (state_q == ST_WAIT0)) ? resp0_q :
                             ((state_q == ST_SEND1) || (state_q == ST_WAIT1)) ? resp1_q : 8'h00;
    assign bus.busy        = (state_q != ST_IDLE) && (state_q != ST_GET_ADDR);

endmodule
